// File: rtl/display_arb_pkg.sv
// display_arb_pkg: source ids, blank pattern, arbiter state type and priority helpers.
`default_nettype none

package display_arb_pkg;

    localparam int SRC_MENU   = 0;
    localparam int SRC_JUEGO  = 1;
    localparam int SRC_ALERTA = 2;
    localparam int N_SRC      = 3;

    localparam logic [6:0] BLANK_SEG = 7'h7F;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // One-hot of the highest-priority active request: alerta > juego > menu.
    function automatic logic [N_SRC-1:0] prio_onehot(input logic [N_SRC-1:0] r);
        prio_onehot = '0;
        if (r[SRC_ALERTA])     prio_onehot[SRC_ALERTA] = 1'b1;
        else if (r[SRC_JUEGO]) prio_onehot[SRC_JUEGO]  = 1'b1;
        else if (r[SRC_MENU])  prio_onehot[SRC_MENU]   = 1'b1;
    endfunction

    function automatic logic [1:0] owner_index(input logic [N_SRC-1:0] g);
        case (g)
            3'b100:  owner_index = 2'd2;
            3'b010:  owner_index = 2'd1;
            default: owner_index = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_arbiter_scan_timer.sv
// scan_timer: digit-slot prescaler and 2-bit digit index with slot and frame strobes.
`default_nettype none

module scan_timer #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] idx,
    output logic       scan_tick,
    output logic       frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc;

    assign scan_tick  = (presc == PW'(REFRESH_DIV - 1));
    assign frame_tick = scan_tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (scan_tick) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_arbiter.sv
// display_arbiter: frame-aligned priority sharing of the 4-digit 7-segment scan.
// Optional alerta blinking is enabled by defining DISPLAY_ARBITER_BLINK_EN.
`default_nettype none

module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int MIN_HOLD     = 8,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  req,
    input  logic [83:0]       src_digits,
    output logic [N_SRC-1:0]  grant,
    output logic [6:0]        display_controlador,
    output logic [3:0]        enable_display,
    output logic              frame_tick
);

    localparam int HW = $clog2(MIN_HOLD + 1);

    if (REFRESH_DIV < 2 || MIN_HOLD < 1 || BLINK_FRAMES < 1) begin : g_param_invalid
    end

    logic [1:0]       idx;
    logic             scan_tick;
    logic             frame_evt;
    arb_state_t       state, state_next;
    logic [N_SRC-1:0] grant_next, pick;
    logic [HW-1:0]    hold, hold_next, hold_inc;
    logic             blank;
    logic [6:0]       digit;
    int               base;

    scan_timer #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .scan_tick  (scan_tick),
        .frame_tick (frame_tick)
    );

    assign frame_evt = scan_tick && frame_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            hold  <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        hold_next  = hold;
        pick       = prio_onehot(req);
        hold_inc   = (hold >= HW'(MIN_HOLD)) ? hold : hold + 1'b1;
        if (frame_evt) begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state_next = ST_OWN;
                        grant_next = pick;
                        hold_next  = '0;
                    end
                end
                ST_OWN: begin
                    if ((req & grant) == '0) begin
                        // Owner released: hand over directly, or fall back to idle.
                        state_next = (|req) ? ST_OWN : ST_IDLE;
                        grant_next = pick;
                        hold_next  = '0;
                    end else if (pick != grant && hold_inc >= HW'(MIN_HOLD)) begin
                        grant_next = pick;
                        hold_next  = '0;
                    end else begin
                        hold_next  = hold_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    hold_next  = '0;
                end
            endcase
        end
    end

`ifdef DISPLAY_ARBITER_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_evt) begin
            if (grant_next[SRC_ALERTA] && !grant[SRC_ALERTA]) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (grant[SRC_ALERTA]) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt   <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign blank = blink_phase && grant[SRC_ALERTA];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        base  = (int'(owner_index(grant)) * 4 + int'(idx)) * 7;
        digit = src_digits[base +: 7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_display      <= 4'b1111;
            display_controlador <= BLANK_SEG;
        end else begin
            enable_display      <= ~(4'b0001 << idx);
            display_controlador <= (grant == '0 || blank) ? BLANK_SEG : digit;
        end
    end

endmodule

`default_nettype wire
